// File: rtl/y86_fde_stage_if.sv
// rtl/y86_fde_stage_if.sv - fetch/decode/execute bus between datapath and the y86 front end
interface y86_fde_stage_if;
    logic [63:0] PC;
    logic        imem_we;
    logic [63:0] imem_waddr;
    logic [7:0]  imem_wdata;
    logic [63:0] reg_memrA;
    logic [63:0] reg_memrB;
    logic [63:0] reg_memr4;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valE;
    logic        cnd;
    logic        instr_valid;
    logic        imem_error;

    modport master (
        output PC, imem_we, imem_waddr, imem_wdata, reg_memrA, reg_memrB, reg_memr4,
        input  icode, ifun, rA, rB, valC, valP, valA, valB, valE, cnd, instr_valid, imem_error
    );

    modport slave (
        input  PC, imem_we, imem_waddr, imem_wdata, reg_memrA, reg_memrB, reg_memr4,
        output icode, ifun, rA, rB, valC, valP, valA, valB, valE, cnd, instr_valid, imem_error
    );
endinterface

// File: rtl/y86_fde_stage.sv
// rtl/y86_fde_stage.sv - sequential Y86-64 fetch, decode and execute stage with CC register
module y86_fde_stage #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    y86_fde_stage_if.slave  bus
);
    localparam int          AW    = $clog2(IMEM_BYTES);
    localparam logic [63:0] LIMIT = 64'(IMEM_BYTES);

    localparam logic [3:0] I_CMOV = 4'h2, I_IRMOV = 4'h3, I_RMMOV = 4'h4, I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ  = 4'h6, I_JXX   = 4'h7, I_CALL  = 4'h8, I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH = 4'hA, I_POP   = 4'hB;

    logic [7:0] mem_q [IMEM_BYTES];
    logic [2:0] cc_q, cc_d;     // {ZF, SF, OF}

    logic [7:0] fb [10];
    logic [9:0] oob;

    // Ten bytes are always fetched; out-of-range ones read as zero and only
    // count as an error when the decoded length actually reaches them.
    for (genvar g = 0; g < 10; g++) begin : g_fetch
        logic [63:0] addr;
        assign addr   = bus.PC + 64'(g);
        assign oob[g] = addr >= LIMIT;
        assign fb[g]  = oob[g] ? 8'h00 : mem_q[addr[AW-1:0]];
    end

    logic [3:0]  icode, ifun, ra, rb;
    logic        valid, need_regs, need_valc, cnd, zf, sf, of, cc_we;
    logic [3:0]  len;
    logic [9:0]  len_mask;
    logic [63:0] valc, vala, valb, vale;

    always_comb begin
        icode     = fb[0][7:4];
        ifun      = fb[0][3:0];
        valid     = icode <= I_POP;
        need_regs = icode inside {I_CMOV, I_IRMOV, I_RMMOV, I_MRMOV, I_OPQ, I_PUSH, I_POP};
        need_valc = icode inside {I_IRMOV, I_RMMOV, I_MRMOV, I_JXX, I_CALL};
        ra        = need_regs ? fb[1][7:4] : 4'hF;
        rb        = need_regs ? fb[1][3:0] : 4'hF;
        valc      = 64'd0;
        if (need_valc)
            valc = need_regs ? {fb[9], fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2]}
                             : {fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2], fb[1]};
        len       = 4'd1 + (need_regs ? 4'd1 : 4'd0) + (need_valc ? 4'd8 : 4'd0);
        len_mask  = need_valc ? (need_regs ? 10'h3FF : 10'h1FF) : (need_regs ? 10'h003 : 10'h001);

        vala = 64'd0;
        valb = 64'd0;
        case (icode)
            I_CMOV:         vala = bus.reg_memrA;
            I_RMMOV, I_OPQ: begin vala = bus.reg_memrA; valb = bus.reg_memrB; end
            I_MRMOV:        valb = bus.reg_memrB;
            I_PUSH:         begin vala = bus.reg_memrA; valb = bus.reg_memr4; end
            I_RET, I_POP:   begin vala = bus.reg_memr4; valb = bus.reg_memr4; end
            I_CALL:         valb = bus.reg_memr4;
            default:        ;
        endcase

        vale = 64'd0;
        case (icode)
            I_CMOV:           vale = vala;
            I_IRMOV:          vale = valc;
            I_RMMOV, I_MRMOV: vale = valb + valc;
            I_OPQ: begin
                case (ifun)
                    4'h0:    vale = valb + vala;
                    4'h1:    vale = valb - vala;
                    4'h2:    vale = valb & vala;
                    4'h3:    vale = valb ^ vala;
                    default: vale = 64'd0;
                endcase
            end
            I_CALL, I_PUSH:   vale = valb - 64'd8;
            I_RET, I_POP:     vale = valb + 64'd8;
            default:          ;
        endcase

        {zf, sf, of} = cc_q;
        cnd = 1'b0;
        if (icode == I_JXX || icode == I_CMOV) begin
            case (ifun)
                4'h0:    cnd = 1'b1;
                4'h1:    cnd = (sf ^ of) | zf;
                4'h2:    cnd = sf ^ of;
                4'h3:    cnd = zf;
                4'h4:    cnd = ~zf;
                4'h5:    cnd = ~(sf ^ of);
                4'h6:    cnd = ~(sf ^ of) & ~zf;
                default: cnd = 1'b0;
            endcase
        end

        cc_we = (icode == I_OPQ) && (ifun <= 4'h3);
        cc_d  = cc_q;
        if (cc_we) begin
            cc_d[2] = vale == 64'd0;
            cc_d[1] = vale[63];
            case (ifun)
                4'h0:    cc_d[0] = (vala[63] == valb[63]) && (vale[63] != vala[63]);
                4'h1:    cc_d[0] = (vala[63] != valb[63]) && (vale[63] != valb[63]);
                default: cc_d[0] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cc_q <= 3'b100;
        else        cc_q <= cc_d;
    end

    always_ff @(posedge clk) begin
        if (bus.imem_we && bus.imem_waddr < LIMIT)
            mem_q[bus.imem_waddr[AW-1:0]] <= bus.imem_wdata;
    end

    assign bus.icode       = icode;
    assign bus.ifun        = ifun;
    assign bus.rA          = ra;
    assign bus.rB          = rb;
    assign bus.valC        = valc;
    assign bus.valP        = bus.PC + {60'd0, len};
    assign bus.valA        = vala;
    assign bus.valB        = valb;
    assign bus.valE        = vale;
    assign bus.cnd         = cnd;
    assign bus.instr_valid = valid;
    assign bus.imem_error  = |(oob & len_mask);
endmodule

// File: tb/tb_y86_fde_stage.sv
// tb/tb_y86_fde_stage.sv - scoreboard bench for the y86 fetch/decode/execute stage
module tb_y86_fde_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    y86_fde_stage_if bus ();
    y86_fde_stage #(.IMEM_BYTES(1024)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        string       nm;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp, vala, valb, vale;
        logic        cnd, valid, err;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic cmp(input string nm, input string f, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s actual=%h required=%h", nm, f, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.nm, "icode", 64'(bus.icode), 64'(e.icode));
            cmp(e.nm, "ifun",  64'(bus.ifun),  64'(e.ifun));
            cmp(e.nm, "rA",    64'(bus.rA),    64'(e.ra));
            cmp(e.nm, "rB",    64'(bus.rB),    64'(e.rb));
            cmp(e.nm, "valC",  bus.valC, e.valc);
            cmp(e.nm, "valP",  bus.valP, e.valp);
            cmp(e.nm, "valA",  bus.valA, e.vala);
            cmp(e.nm, "valB",  bus.valB, e.valb);
            cmp(e.nm, "valE",  bus.valE, e.vale);
            cmp(e.nm, "cnd",   64'(bus.cnd), 64'(e.cnd));
            cmp(e.nm, "instr_valid", 64'(bus.instr_valid), 64'(e.valid));
            cmp(e.nm, "imem_error",  64'(bus.imem_error),  64'(e.err));
        end
    end

    task automatic load(input logic [63:0] a, input logic [79:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            bus.imem_we    = 1'b1;
            bus.imem_waddr = a + 64'(i);
            bus.imem_wdata = data[8*(n-1-i) +: 8];
            @(posedge clk);
            #1;
        end
        bus.imem_we = 1'b0;
    endtask

    task automatic step(input string nm, input logic [63:0] pc, input logic [63:0] ra_v,
                        input logic [63:0] rb_v, input logic [63:0] r4_v, input logic rst,
                        input logic [3:0] icode, input logic [3:0] ifun, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] valc, input logic [63:0] valp,
                        input logic [63:0] vala, input logic [63:0] valb, input logic [63:0] vale,
                        input logic cnd, input logic valid, input logic err);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n         = rst;
        bus.PC        = pc;
        bus.reg_memrA = ra_v;
        bus.reg_memrB = rb_v;
        bus.reg_memr4 = r4_v;
        e = '{nm, icode, ifun, ra, rb, valc, valp, vala, valb, vale, cnd, valid, err};
        sb.push_back(e);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s.drain actual=%0d required=0", nm, sb.size());
            sb.delete();
        end
    endtask

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    initial begin
        rst_n = 1'b0;
        bus.PC = 64'd40;
        bus.imem_we = 1'b0;
        bus.imem_waddr = '0;
        bus.imem_wdata = '0;
        bus.reg_memrA = '0;
        bus.reg_memrB = '0;
        bus.reg_memr4 = '0;
        @(posedge clk);
        #1;
        load(0,    80'h30F3_0500_0000_0000_0000, 10);
        load(10,   80'h6023, 2);
        load(12,   80'h6111, 2);
        load(14,   80'h73_4000_0000_0000_0000, 9);
        load(23,   80'hA02F, 2);
        load(25,   80'h90, 1);
        load(26,   80'h2201, 2);
        load(28,   80'h2101, 2);
        load(30,   80'h74_8000_0000_0000_0000, 9);
        load(39,   80'hD0, 1);
        load(40,   80'h10, 1);
        load(41,   80'h72_0000_0000_0000_0000, 9);
        load(50,   80'h6212, 2);
        load(52,   80'h6312, 2);
        load(1023, 80'h30, 1);

        //    name        PC    rA     rB      r4  rst  ic    if    rA    rB    valC   valP  valA    valB    valE    cnd  vld  err
        step("rst_je",    14,   0,     0,      0,  1, 4'h7, 4'h3, 4'hF, 4'hF, 64'h40, 23,   0,      0,      0,      1,   1,   0);
        step("irmovq",    0,    'h11,  'h22,   'h33, 1, 4'h3, 4'h0, 4'hF, 4'h3, 5,     10,   0,      0,      5,      0,   1,   0);
        step("addq",      10,   2,     3,      0,  1, 4'h6, 4'h0, 4'h2, 4'h3, 0,      12,   2,      3,      5,      0,   1,   0);
        step("je_nz",     14,   0,     0,      0,  1, 4'h7, 4'h3, 4'hF, 4'hF, 64'h40, 23,   0,      0,      0,      0,   1,   0);
        step("jl_pos",    41,   0,     0,      0,  1, 4'h7, 4'h2, 4'hF, 4'hF, 0,      50,   0,      0,      0,      0,   1,   0);
        step("subq",      12,   7,     7,      0,  1, 4'h6, 4'h1, 4'h1, 4'h1, 0,      14,   7,      7,      0,      0,   1,   0);
        step("je_z",      14,   0,     0,      0,  1, 4'h7, 4'h3, 4'hF, 4'hF, 64'h40, 23,   0,      0,      0,      1,   1,   0);
        step("pushq",     23,   2,     'h99,   8,  1, 4'hA, 4'h0, 4'h2, 4'hF, 0,      25,   2,      8,      0,      0,   1,   0);
        step("ret",       25,   5,     6,      4,  1, 4'h9, 4'h0, 4'hF, 4'hF, 0,      26,   4,      4,      12,     0,   1,   0);
        step("addq_ovf",  10,   1,     MAXP,   0,  1, 4'h6, 4'h0, 4'h2, 4'h3, 0,      12,   1,      MAXP,   MINN,   0,   1,   0);
        step("cmovl",     26,   'h55,  'h66,   0,  1, 4'h2, 4'h2, 4'h0, 4'h1, 0,      28,   'h55,   0,      'h55,   0,   1,   0);
        step("cmovle",    28,   'h55,  'h66,   0,  1, 4'h2, 4'h1, 4'h0, 4'h1, 0,      30,   'h55,   0,      'h55,   0,   1,   0);
        step("jl_ovf",    41,   0,     0,      0,  1, 4'h7, 4'h2, 4'hF, 4'hF, 0,      50,   0,      0,      0,      0,   1,   0);
        step("subq_ovf",  12,   1,     MINN,   0,  1, 4'h6, 4'h1, 4'h1, 4'h1, 0,      14,   1,      MINN,   MAXP,   0,   1,   0);
        step("jl_neg",    41,   0,     0,      0,  1, 4'h7, 4'h2, 4'hF, 4'hF, 0,      50,   0,      0,      0,      1,   1,   0);
        step("rst_addq",  10,   1,     1,      0,  0, 4'h6, 4'h0, 4'h2, 4'h3, 0,      12,   1,      1,      2,      0,   1,   0);
        step("jne_z",     30,   0,     0,      0,  1, 4'h7, 4'h4, 4'hF, 4'hF, 64'h80, 39,   0,      0,      0,      0,   1,   0);
        step("bad_icode", 39,   'h11,  'h22,   'h33, 1, 4'hD, 4'h0, 4'hF, 4'hF, 0,     40,   0,      0,      0,      0,   0,   0);
        step("edge",      1023, 0,     0,      0,  1, 4'h3, 4'h0, 4'h0, 4'h0, 0,      1033, 0,      0,      0,      0,   1,   1);
        step("oob",       2000, 0,     0,      0,  1, 4'h0, 4'h0, 4'hF, 4'hF, 0,      2001, 0,      0,      0,      0,   1,   1);
        step("andq",      50,   'hF0F0, 'hFF00, 0, 1, 4'h6, 4'h2, 4'h1, 4'h2, 0,      52,   'hF0F0, 'hFF00, 'hF000, 0,   1,   0);
        step("xorq",      52,   'hF0F0, 'hFF00, 0, 1, 4'h6, 4'h3, 4'h1, 4'h2, 0,      54,   'hF0F0, 'hFF00, 'h0FF0, 0,   1,   0);
        step("jne_nz",    30,   0,     0,      0,  1, 4'h7, 4'h4, 4'hF, 4'hF, 64'h80, 39,   0,      0,      0,      1,   1,   0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
